// File: rtl/fpnew_fma_issue_arbiter.sv
// fpnew_fma_issue_arbiter: round-robin issue arbiter that shares one pipelined FMA
// unit among NumReq requesters. It caps in-flight ops per requester and routes each
// result back to its issuer using the ID carried through the unit.
// Ports:
//   clk_i/rst_i/flush_i         clock, sync active-high reset, sync flush (forwarded as unit_flush_o)
//   req_valid/ready/payload     per-requester issue side (zero-cycle combinational grant)
//   unit_valid/ready/payload/id issue side toward the FMA
//   unit_out_valid/ready/id/payload  result side from the FMA
//   resp_valid/ready/payload    per-requester result side (one-hot valid, broadcast payload)
//   busy_o, proto_err_o         activity status and sticky protocol error
module fpnew_fma_issue_arbiter #(
    parameter  int unsigned NumReq         = 4,
    parameter  int unsigned PayloadWidth   = 64,
    parameter  int unsigned MaxOutstanding = 4,
    localparam int unsigned IdWidth        = $clog2(NumReq),
    localparam int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flush_i,
    input  logic [NumReq-1:0]                   req_valid_i,
    output logic [NumReq-1:0]                   req_ready_o,
    input  logic [NumReq-1:0][PayloadWidth-1:0] req_payload_i,
    output logic                                unit_valid_o,
    input  logic                                unit_ready_i,
    output logic [PayloadWidth-1:0]             unit_payload_o,
    output logic [IdWidth-1:0]                  unit_id_o,
    output logic                                unit_flush_o,
    input  logic                                unit_out_valid_i,
    output logic                                unit_out_ready_o,
    input  logic [IdWidth-1:0]                  unit_out_id_i,
    input  logic [PayloadWidth-1:0]             unit_out_payload_i,
    output logic [NumReq-1:0]                   resp_valid_o,
    input  logic [NumReq-1:0]                   resp_ready_i,
    output logic [PayloadWidth-1:0]             resp_payload_o,
    output logic                                busy_o,
    output logic                                proto_err_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                             state_q, state_d;
    logic [IdWidth-1:0]                 rr_q, lock_id_q, lock_id_d;
    logic [IdWidth-1:0]                 rr_grant, grant, rr_next;
    logic [NumReq-1:0][CntWidth-1:0]    cnt_q, cnt_d;
    logic                               err_q, lock_err, cnt_err;
    logic [NumReq-1:0]                  eligible;
    logic                               rr_found, cand_valid;
    logic                               live, issue_hs, resp_hs, out_id_ok;

    // Reset and flush both kill every handshake in the cycle they are asserted.
    assign live = ~rst_i & ~flush_i;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            eligible[i] = req_valid_i[i] & (cnt_q[i] < CntWidth'(MaxOutstanding));
        end
    end

    // Round-robin pick: first eligible index starting at rr_q, wrapping modulo NumReq.
    always_comb begin
        int idx;
        idx      = 0;
        rr_grant = rr_q;
        rr_found = 1'b0;
        for (int k = 0; k < int'(NumReq); k++) begin
            idx = int'(rr_q) + k;
            if (idx >= int'(NumReq)) begin
                idx = idx - int'(NumReq);
            end
            if (!rr_found && eligible[idx]) begin
                rr_found = 1'b1;
                rr_grant = IdWidth'(idx);
            end
        end
    end

    // While locked the grant is pinned to the stalled requester. Its count cannot
    // have grown since it was granted, so only its valid matters here.
    always_comb begin
        if (state_q == LOCKED) begin
            grant      = lock_id_q;
            cand_valid = req_valid_i[lock_id_q];
        end else begin
            grant      = rr_grant;
            cand_valid = rr_found;
        end
    end

    assign unit_valid_o   = cand_valid & live;
    assign unit_id_o      = grant;
    assign unit_payload_o = req_payload_i[grant];
    assign unit_flush_o   = flush_i;
    assign issue_hs       = unit_valid_o & unit_ready_i;
    assign req_ready_o    = issue_hs ? (NumReq'(1) << grant) : '0;
    assign rr_next        = (grant == IdWidth'(NumReq - 1)) ? '0 : grant + IdWidth'(1);

    // With a non power-of-two NumReq an out-of-range returned ID must not route.
    if ((1 << IdWidth) == NumReq) begin : g_id_full
        assign out_id_ok = 1'b1;
    end else begin : g_id_partial
        assign out_id_ok = (unit_out_id_i < IdWidth'(NumReq));
    end

    assign unit_out_ready_o = resp_ready_i[unit_out_id_i] & out_id_ok & live;
    assign resp_hs          = unit_out_valid_i & unit_out_ready_o;
    assign resp_valid_o     = (unit_out_valid_i & out_id_ok & live) ? (NumReq'(1) << unit_out_id_i) : '0;
    assign resp_payload_o   = unit_out_payload_i;

    // A result for a requester with nothing outstanding is an error and never
    // underflows the counter; a same-cycle issue for that ID does not rescue it.
    always_comb begin
        cnt_d   = cnt_q;
        cnt_err = 1'b0;
        for (int i = 0; i < int'(NumReq); i++) begin
            if (resp_hs && unit_out_id_i == IdWidth'(i) && cnt_q[i] == '0) begin
                cnt_err = 1'b1;
            end
            if (issue_hs && grant == IdWidth'(i)) begin
                if (!(resp_hs && unit_out_id_i == IdWidth'(i))) begin
                    cnt_d[i] = cnt_q[i] + CntWidth'(1);
                end
            end else if (resp_hs && unit_out_id_i == IdWidth'(i) && cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CntWidth'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        lock_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (unit_valid_o && !unit_ready_i) begin
                    state_d   = LOCKED;
                    lock_id_d = grant;
                end
            end
            LOCKED: begin
                if (!req_valid_i[lock_id_q]) begin
                    state_d  = IDLE;
                    lock_err = 1'b1;
                end else if (unit_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            lock_id_q <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else if (flush_i) begin
            state_q   <= IDLE;
            lock_id_q <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            cnt_q     <= cnt_d;
            if (issue_hs) begin
                rr_q <= rr_next;
            end
            if (lock_err || cnt_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign busy_o      = (state_q == LOCKED) | (|cnt_q);
    assign proto_err_o = err_q;

endmodule

// File: tb/tb_fpnew_fma_issue_arbiter.sv
module tb_fpnew_fma_issue_arbiter;

    localparam int N    = 4;
    localparam int PW   = 64;
    localparam int MAXO = 4;
    localparam int IW   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst, flush;
    logic [N-1:0]           req_valid, req_ready;
    logic [N-1:0][PW-1:0]   req_payload;
    logic                   unit_valid, unit_ready, unit_flush;
    logic [PW-1:0]          unit_payload;
    logic [IW-1:0]          unit_id;
    logic                   unit_out_valid, unit_out_ready;
    logic [IW-1:0]          unit_out_id;
    logic [PW-1:0]          unit_out_payload;
    logic [N-1:0]           resp_valid, resp_ready;
    logic [PW-1:0]          resp_payload;
    logic                   busy, proto_err;

    fpnew_fma_issue_arbiter #(
        .NumReq(N), .PayloadWidth(PW), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_payload_i(req_payload),
        .unit_valid_o(unit_valid), .unit_ready_i(unit_ready), .unit_payload_o(unit_payload),
        .unit_id_o(unit_id), .unit_flush_o(unit_flush),
        .unit_out_valid_i(unit_out_valid), .unit_out_ready_o(unit_out_ready),
        .unit_out_id_i(unit_out_id), .unit_out_payload_i(unit_out_payload),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_payload_o(resp_payload),
        .busy_o(busy), .proto_err_o(proto_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: outstanding count per requester, rotating priority pointer,
    // pinned requester while the unit stalls, sticky error.
    int m_cnt [N];
    int m_rr;
    bit m_lock;
    int m_lid;
    bit m_err;
    int last_g;
    bit last_issue;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge with inputs applied: checks the outputs,
    // advances the model across the next rising edge, returns at the next falling edge.
    task automatic tick();
        int g, oid;
        bit v, live, issue, rhs, any_cnt;
        logic [N-1:0] exp_rdy, exp_rv;
        #1;
        live = !rst && !flush;
        g = 0;
        v = 0;
        if (m_lock) begin
            g = m_lid;
            v = req_valid[g];
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_rr + k) % N;
                if (!v && req_valid[j] && m_cnt[j] < MAXO) begin
                    g = j;
                    v = 1;
                end
            end
        end
        v = v && live;
        exp_rdy = '0;
        if (v && unit_ready) exp_rdy[g] = 1'b1;
        oid = int'(unit_out_id);
        exp_rv = '0;
        if (live && unit_out_valid) exp_rv[oid] = 1'b1;
        any_cnt = 0;
        for (int i = 0; i < N; i++) if (m_cnt[i] != 0) any_cnt = 1;

        check("unit_valid", unit_valid, v);
        check("req_ready", req_ready, exp_rdy);
        if (v) begin
            check("unit_id", unit_id, g);
            check("unit_payload", unit_payload, req_payload[g]);
        end
        check("unit_flush", unit_flush, flush);
        check("resp_valid", resp_valid, exp_rv);
        check("unit_out_ready", unit_out_ready, live && resp_ready[oid]);
        check("resp_payload", resp_payload, unit_out_payload);
        check("busy", busy, m_lock || any_cnt);
        check("proto_err", proto_err, m_err);

        issue = v && unit_ready;
        rhs   = live && unit_out_valid && resp_ready[oid];
        last_g     = g;
        last_issue = issue;

        if (rst) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_rr = 0; m_lock = 0; m_lid = 0; m_err = 0;
        end else if (flush) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_rr = 0; m_lock = 0;
        end else begin
            if (rhs && m_cnt[oid] == 0) m_err = 1;
            if (!(issue && rhs && g == oid)) begin
                if (issue) m_cnt[g] = m_cnt[g] + 1;
                if (rhs && m_cnt[oid] > 0) m_cnt[oid] = m_cnt[oid] - 1;
            end
            if (issue) m_rr = (g + 1) % N;
            if (m_lock) begin
                if (!req_valid[m_lid]) begin
                    m_err  = 1;
                    m_lock = 0;
                end else if (unit_ready) begin
                    m_lock = 0;
                end
            end else if (v && !unit_ready) begin
                m_lock = 1;
                m_lid  = g;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rnd_payloads();
        for (int i = 0; i < N; i++) req_payload[i] = {$urandom, $urandom};
        unit_out_payload = {$urandom, $urandom};
    endtask

    task automatic drive(input logic [N-1:0] v, input logic rdy, input logic ov, input int oid);
        rst = 0;
        flush = 0;
        req_valid = v;
        unit_ready = rdy;
        unit_out_valid = ov;
        unit_out_id = IW'(oid);
        resp_ready = '1;
        rnd_payloads();
    endtask

    task automatic do_flush();
        drive('0, 1'b1, 1'b0, 0);
        flush = 1;
        tick();
    endtask

    initial begin
        logic [PW-1:0] p1;
        bit want [N];
        int cands[$];
        int ids[6];

        rst = 1; flush = 0; req_valid = '0; unit_ready = 0; unit_out_valid = 0;
        unit_out_id = '0; resp_ready = '1; req_payload = '0; unit_out_payload = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_rr = 0; m_lock = 0; m_lid = 0; m_err = 0; last_g = 0; last_issue = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_err", proto_err, 1'b0);
        tick();

        // Round-robin order 0,1,2,3,0,... with results recycled each cycle.
        for (int k = 0; k < 8; k++) begin
            drive('1, 1'b1, k > 0, (k + 3) % 4);
            #1;
            check("t1_order", unit_id, k % 4);
            tick();
        end

        // Requester 2 fills up, is skipped while full, reopens after one result.
        do_flush();
        for (int k = 0; k < 4; k++) begin
            drive(4'b0100, 1'b1, 1'b0, 0);
            #1;
            check("t2_issue", req_ready, 4'b0100);
            tick();
        end
        drive(4'b0110, 1'b1, 1'b0, 0);
        #1;
        check("t2_block", req_ready, 4'b0010);
        tick();
        drive(4'b0100, 1'b1, 1'b1, 2);
        #1;
        check("t2_full", unit_valid, 1'b0);
        tick();
        drive(4'b0100, 1'b1, 1'b0, 0);
        #1;
        check("t2_reopen", req_ready, 4'b0100);
        tick();

        // Stall holds grant and payload on requester 1; next grant goes to 2.
        do_flush();
        drive(4'b0010, 1'b0, 1'b0, 0);
        p1 = req_payload[1];
        #1;
        check("t3_hold_id", unit_id, 1);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(4'b0011, 1'b0, 1'b0, 0);
            req_payload[1] = p1;
            #1;
            check("t3_hold_id", unit_id, 1);
            check("t3_hold_pl", unit_payload, p1);
            tick();
        end
        drive(4'b0011, 1'b1, 1'b0, 0);
        req_payload[1] = p1;
        #1;
        check("t3_release", req_ready, 4'b0010);
        tick();
        drive(4'b0101, 1'b1, 1'b0, 0);
        #1;
        check("t3_next", unit_id, 2);
        tick();

        // Same-cycle issue and result for ID 3 leaves its count; stray result errors.
        do_flush();
        repeat (2) begin
            drive(4'b1000, 1'b1, 1'b0, 0);
            tick();
        end
        drive(4'b1000, 1'b1, 1'b1, 3);
        #1;
        check("t4_both_rdy", req_ready, 4'b1000);
        check("t4_both_ordy", unit_out_ready, 1'b1);
        tick();
        repeat (2) begin
            drive(4'b1000, 1'b1, 1'b0, 0);
            tick();
        end
        drive(4'b1000, 1'b1, 1'b0, 0);
        #1;
        check("t4_cnt_kept", unit_valid, 1'b0);
        tick();
        drive('0, 1'b1, 1'b1, 0);
        tick();
        drive('0, 1'b1, 1'b0, 0);
        #1;
        check("t4_err", proto_err, 1'b1);
        tick();
        do_flush();
        drive('0, 1'b1, 1'b0, 0);
        #1;
        check("t4_err_sticky", proto_err, 1'b1);
        tick();

        // Flush while locked clears counts, lock and pointer.
        do_flush();
        ids = '{3, 3, 3, 0, 1, 1};
        foreach (ids[i]) begin
            drive(N'(1) << ids[i], 1'b1, 1'b0, 0);
            tick();
        end
        drive(4'b0010, 1'b0, 1'b0, 0);
        tick();
        drive(4'b0010, 1'b1, 1'b0, 0);
        flush = 1;
        #1;
        check("t5_flush_rdy", req_ready, 4'b0000);
        check("t5_flush_vld", unit_valid, 1'b0);
        tick();
        drive('0, 1'b1, 1'b0, 0);
        #1;
        check("t5_busy", busy, 1'b0);
        tick();
        drive(4'b0101, 1'b1, 1'b0, 0);
        #1;
        check("t5_rr", unit_id, 0);
        tick();

        // Reset mid-stream.
        repeat (3) begin
            drive('1, 1'b1, 1'b0, 0);
            tick();
        end
        drive('1, 1'b1, 1'b1, 0);
        rst = 1;
        #1;
        check("t6_rst_rdy", req_ready, 4'b0000);
        check("t6_rst_vld", unit_valid, 1'b0);
        check("t6_rst_rv", resp_valid, 4'b0000);
        check("t6_rst_ordy", unit_out_ready, 1'b0);
        tick();
        drive('1, 1'b1, 1'b0, 0);
        #1;
        check("t6_first", unit_id, 0);
        check("t6_err_clr", proto_err, 1'b0);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < N; i++) want[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!want[i]) want[i] = ($urandom % 3 == 0);
                else if ($urandom % 100 == 0) want[i] = 0;
                req_valid[i] = want[i];
                resp_ready[i] = ($urandom % 5 != 0);
            end
            rst = ($urandom % 300 == 0);
            flush = ($urandom % 60 == 0);
            unit_ready = ($urandom % 4 != 0);
            cands.delete();
            for (int i = 0; i < N; i++) if (m_cnt[i] > 0) cands.push_back(i);
            unit_out_valid = 0;
            unit_out_id = IW'($urandom % N);
            if ($urandom % 100 == 0) begin
                unit_out_valid = 1;
            end else if (cands.size() > 0 && $urandom % 2 == 0) begin
                unit_out_valid = 1;
                unit_out_id = IW'(cands[$urandom % cands.size()]);
            end
            rnd_payloads();
            tick();
            if (last_issue) want[last_g] = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
